// File: rtl/shift_exec_pipe.sv
// Two-stage shift unit (LSL/LSR/ASR/ROL) built around one left barrel shifter; result and C/Z/N flags are registered.
// Result appears two cycles after accept; a stalled output freezes stage 2 and lets stage 1 fill once before in_ready drops.
module shift_exec_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [WIDTH-1:0] pre_q, pre_d;
    logic             sign_q, sign_d;
    logic             carry_q, carry_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;

    logic             adv2;
    logic             accept;
    logic             deliver;

    always_comb begin
        adv2     = s1_valid_q & (~out_valid_q | out_ready);
        in_ready = ~s1_valid_q | adv2;
        accept   = in_valid & in_ready;
        deliver  = out_valid_q & out_ready;
    end

    // Stage 1: right shifts are turned into left shifts by reversing the operand;
    // ASR of a negative value additionally inverts so zero fill becomes sign fill.
    logic [WIDTH-1:0] rev_opnd;
    logic [WIDTH-1:0] pre_in;
    logic             carry_in;
    logic [SHW-1:0]   neg_shamt;

    always_comb begin
        rev_opnd  = bit_rev(operand);
        neg_shamt = '0 - shamt;
        pre_in    = operand;
        carry_in  = 1'b0;
        case (op)
            OP_LSR:  pre_in = rev_opnd;
            OP_ASR:  pre_in = operand[WIDTH-1] ? ~rev_opnd : rev_opnd;
            default: pre_in = operand;
        endcase
        if (shamt != '0) begin
            if (op == OP_LSR || op == OP_ASR) begin
                carry_in = operand[shamt - 1'b1];
            end else begin
                carry_in = operand[neg_shamt];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        op_d       = op_q;
        shamt_d    = shamt_q;
        pre_d      = pre_q;
        sign_d     = sign_q;
        carry_d    = carry_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            op_d       = op;
            shamt_d    = shamt;
            pre_d      = pre_in;
            sign_d     = (op == OP_ASR) & operand[WIDTH-1];
            carry_d    = carry_in;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: logarithmic left barrel shifter plus postconditioning.
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] rol_wrap;
    logic [WIDTH-1:0] res_new;
    logic [SHW-1:0]   neg_shamt_q;

    always_comb begin
        sh = pre_q;
        for (int i = 0; i < SHW; i++) begin
            if (shamt_q[i]) begin
                sh = sh << (1 << i);
            end
        end
        neg_shamt_q = '0 - shamt_q;
        rol_wrap    = pre_q >> neg_shamt_q;
        res_new     = sh;
        case (op_q)
            OP_LSL:  res_new = sh;
            OP_LSR:  res_new = bit_rev(sh);
            OP_ASR:  res_new = sign_q ? ~bit_rev(sh) : bit_rev(sh);
            OP_ROL:  res_new = (shamt_q == '0) ? pre_q : (sh | rol_wrap);
            default: res_new = sh;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv2) begin
            out_valid_d = 1'b1;
            result_d    = res_new;
            flag_c_d    = carry_q;
            flag_z_d    = (res_new == '0);
            flag_n_d    = res_new[WIDTH-1];
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            op_q        <= '0;
            shamt_q     <= '0;
            pre_q       <= '0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            op_q        <= op_d;
            shamt_q     <= shamt_d;
            pre_q       <= pre_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;

endmodule
